// File: rtl/pwm_output_sequencer.sv
// Start/stop and fault sequencer for one PWM output pair: period-aligned
// start/stop, low-side-only bootstrap charge interval, latched fault shutdown.
module pwm_output_sequencer #(
  parameter int unsigned BOOT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  fault,
  input  logic                  fault_clear,
  input  logic                  period_start,
  input  logic [1:0]            output_mask,
  input  logic [BOOT_WIDTH-1:0] bootstrap_cycles,
  output logic                  counter_run,
  output logic [1:0]            enable_outputs,
  output logic [2:0]            state,
  output logic                  fault_latched
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    BOOTSTRAP = 3'd2,
    RUN       = 3'd3,
    STOPPING  = 3'd4,
    FAULT     = 3'd5
  } seqState_t;

  seqState_t             curState, nextState;
  logic [BOOT_WIDTH-1:0] bootCnt, bootCntNext;
  logic                  counterRunNext;
  logic [1:0]            enableNext;
  logic                  faultLatchedNext;

  always_ff @(posedge clock) begin
    if (!reset) begin
      curState       <= IDLE;
      bootCnt        <= '0;
      counter_run    <= 1'b0;
      enable_outputs <= '0;
      fault_latched  <= 1'b0;
    end else begin
      curState       <= nextState;
      bootCnt        <= bootCntNext;
      counter_run    <= counterRunNext;
      enable_outputs <= enableNext;
      fault_latched  <= faultLatchedNext;
    end
  end

  always_comb begin
    nextState   = curState;
    bootCntNext = bootCnt;
    if (curState == BOOTSTRAP && bootCnt != '0)
      bootCntNext = bootCnt - BOOT_WIDTH'(1);

    if (fault && curState != FAULT) begin
      nextState = FAULT;
    end else begin
      case (curState)
        IDLE: begin
          if (start && !stop) nextState = ARMED;
        end
        ARMED: begin
          if (stop) begin
            nextState = IDLE;
          end else if (period_start) begin
            if (bootstrap_cycles == '0) begin
              nextState = RUN;
            end else begin
              nextState   = BOOTSTRAP;
              bootCntNext = bootstrap_cycles;
            end
          end
        end
        BOOTSTRAP: begin
          // Compare the registered count so RUN always starts on a period boundary.
          if (stop) nextState = IDLE;
          else if (period_start && bootCnt == '0) nextState = RUN;
        end
        RUN: begin
          if (stop) nextState = STOPPING;
        end
        STOPPING: begin
          if (period_start) nextState = IDLE;
        end
        FAULT: begin
          if (fault_clear && !fault) nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they change together with it.
  always_comb begin
    counterRunNext   = 1'b0;
    enableNext       = '0;
    faultLatchedNext = 1'b0;
    case (nextState)
      ARMED:         counterRunNext = 1'b1;
      BOOTSTRAP: begin
        counterRunNext = 1'b1;
        enableNext     = output_mask & 2'b10;
      end
      RUN, STOPPING: begin
        counterRunNext = 1'b1;
        enableNext     = output_mask;
      end
      FAULT:         faultLatchedNext = 1'b1;
      default: ;
    endcase
  end

  assign state = curState;

endmodule

// File: tb/tb_pwm_output_sequencer.sv
// Bench for pwm_output_sequencer: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the sequencer rules.
module tb_pwm_output_sequencer;

  localparam int unsigned BOOT_WIDTH = 16;

  localparam int S_IDLE = 0, S_ARMED = 1, S_BOOT = 2, S_RUN = 3, S_STOP = 4, S_FAULT = 5;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  start, stop, fault, fault_clear, period_start;
  logic [1:0]            output_mask;
  logic [BOOT_WIDTH-1:0] bootstrap_cycles;
  logic                  counter_run;
  logic [1:0]            enable_outputs;
  logic [2:0]            state;
  logic                  fault_latched;

  int checkCount = 0;
  int passCount  = 0;

  int mState = S_IDLE;
  int mBoot  = 0;
  int mMask  = 0;

  pwm_output_sequencer #(.BOOT_WIDTH(BOOT_WIDTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .fault            (fault),
    .fault_clear      (fault_clear),
    .period_start     (period_start),
    .output_mask      (output_mask),
    .bootstrap_cycles (bootstrap_cycles),
    .counter_run      (counter_run),
    .enable_outputs   (enable_outputs),
    .state            (state),
    .fault_latched    (fault_latched)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  // Reference model: one transition per clock, written straight from the rules.
  task automatic modelEdge();
    int nxt;
    if (!reset) begin
      mState = S_IDLE;
      mBoot  = 0;
      mMask  = 0;
      return;
    end
    nxt = mState;
    if (fault && mState != S_FAULT) nxt = S_FAULT;
    else if (mState == S_FAULT) begin
      if (fault_clear && !fault) nxt = S_IDLE;
    end else if (mState == S_IDLE) begin
      if (start && !stop) nxt = S_ARMED;
    end else if (mState == S_ARMED) begin
      if (stop) nxt = S_IDLE;
      else if (period_start) nxt = (bootstrap_cycles == 0) ? S_RUN : S_BOOT;
    end else if (mState == S_BOOT) begin
      if (stop) nxt = S_IDLE;
      else if (period_start && mBoot == 0) nxt = S_RUN;
    end else if (mState == S_RUN) begin
      if (stop) nxt = S_STOP;
    end else if (mState == S_STOP) begin
      if (period_start) nxt = S_IDLE;
    end
    if (mState == S_BOOT && mBoot > 0) mBoot = mBoot - 1;
    if (mState == S_ARMED && nxt == S_BOOT) mBoot = int'(bootstrap_cycles);
    mState = nxt;
    mMask  = int'(output_mask);
  endtask

  task automatic checkModel();
    int expCr, expEn;
    expCr = (mState == S_ARMED || mState == S_BOOT || mState == S_RUN || mState == S_STOP) ? 1 : 0;
    expEn = (mState == S_RUN || mState == S_STOP) ? mMask : (mState == S_BOOT) ? (mMask & 2) : 0;
    checkVal("model_state", 32'(state), 32'(mState));
    checkVal("model_counter_run", 32'(counter_run), 32'(expCr));
    checkVal("model_enable", 32'(enable_outputs), 32'(expEn));
    checkVal("model_fault_latched", 32'(fault_latched), (mState == S_FAULT) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input logic st, input logic sp, input logic f, input logic fc, input logic ps);
    start = st; stop = sp; fault = f; fault_clear = fc; period_start = ps;
    @(posedge clock);
    modelEdge();
    #1;
    checkModel();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  int psCountdown;

  initial begin
    reset = 1'b0; output_mask = 2'b11; bootstrap_cycles = 16'd10;
    start = 0; stop = 0; fault = 0; fault_clear = 0; period_start = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checkVal("reset_state", 32'(state), 32'd0);
    checkVal("reset_outputs", {29'd0, fault_latched, enable_outputs}, 32'd0);
    reset = 1'b1;

    // Normal start with a 10-cycle bootstrap.
    idle(4);
    step(1, 0, 0, 0, 0);
    checkVal("t1_armed", {30'd0, counter_run, 1'b0} | 32'(state), 32'h3);
    idle(20);
    step(0, 0, 0, 0, 1);
    checkVal("t1_boot_state", 32'(state), 32'd2);
    checkVal("t1_boot_enable", 32'(enable_outputs), 32'd2);
    idle(99);
    checkVal("t1_boot_held", 32'(state), 32'd2);
    step(0, 0, 0, 0, 1);
    checkVal("t1_run", {28'd0, state, 1'b0} | 32'(enable_outputs), 32'h7);

    // Aligned stop 30 cycles before the period wrap.
    step(0, 1, 0, 0, 0);
    checkVal("t3_stopping", 32'(state), 32'd4);
    idle(29);
    checkVal("t3_enable_held", 32'(enable_outputs), 32'd3);
    step(0, 0, 0, 0, 1);
    checkVal("t3_idle", {28'd0, state, counter_run} | 32'(enable_outputs), 32'd0);

    // Zero bootstrap goes straight from ARMED to RUN.
    bootstrap_cycles = 16'd0;
    step(1, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1);
    checkVal("t2_run_direct", 32'(state), 32'd3);
    checkVal("t2_enable", 32'(enable_outputs), 32'd3);

    // Fault during RUN; clear ignored while fault is held.
    step(0, 0, 1, 0, 0);
    checkVal("t4_fault", {28'd0, state, counter_run}, 32'ha);
    checkVal("t4_fault_enable", 32'(enable_outputs), 32'd0);
    step(0, 0, 1, 1, 0);
    checkVal("t4_clear_ignored", 32'(state), 32'd5);
    step(0, 0, 0, 1, 0);
    checkVal("t4_cleared", 32'(state), 32'd0);
    step(1, 0, 0, 0, 0);
    checkVal("t4_rearm", 32'(state), 32'd1);

    // Simultaneous events.
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checkVal("t5_start_stop_idle", 32'(state), 32'd0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    checkVal("t5_fault_beats_stop", 32'(state), 32'd5);
    step(0, 0, 0, 1, 0);
    bootstrap_cycles = 16'd10;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    checkVal("t5_boot_stop", {28'd0, state, 2'b00} | 32'(enable_outputs), 32'd0);

    // Reset mid-bootstrap with fault asserted.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(3);
    reset = 1'b0;
    step(0, 0, 1, 0, 0);
    checkVal("t6_reset_values", {27'd0, state, fault_latched, counter_run} | 32'(enable_outputs), 32'd0);
    reset = 1'b1;
    step(0, 0, 1, 0, 0);
    checkVal("t6_fault_after_reset", 32'(state), 32'd5);
    step(0, 0, 0, 1, 0);

    // Random traffic against the model.
    psCountdown = 10;
    for (int i = 0; i < 4000; i++) begin
      logic ps;
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) output_mask = 2'($urandom);
      if ($urandom_range(0, 29) == 0) bootstrap_cycles = BOOT_WIDTH'($urandom_range(0, 25));
      ps = (psCountdown == 0);
      psCountdown = ps ? $urandom_range(3, 40) : psCountdown - 1;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, ps);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pwm_output_sequencer.md
# pwm_output_sequencer

Start/stop and fault sequencer for one PWM output pair. Sits between the register interface and the PWM counter/pin-control datapath. Drives the counter run enable and the 2-bit output-enable mask consumed by the pin controller (bit0 = high-side A, bit1 = low-side B). Guarantees period-aligned start and stop, a low-side-only bootstrap charge interval, and immediate latched shutdown on fault.

## Interface
- BOOT_WIDTH, 16, width of the bootstrap cycle count.

- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-low; clock clock.
- start  in  1  one-cycle start request.
- stop  in  1  one-cycle stop request.
- fault  in  1  level fault input, synchronous to clock.
- fault_clear  in  1  one-cycle fault acknowledge.
- period_start  in  1  one-cycle pulse from the PWM counter on wrap to zero.
- output_mask  in  2  configured output enables used in RUN/STOPPING.
- bootstrap_cycles  in  BOOT_WIDTH  minimum low-side-only cycles; 0 skips bootstrap.
- counter_run  out  1  PWM counter enable; 0 means counter stopped.
- enable_outputs  out  2  output enables to pin control.
- state  out  3  current state code.
- fault_latched  out  1  high while in FAULT.

## Operation
- States and codes: IDLE=0, ARMED=1, BOOTSTRAP=2, RUN=3, STOPPING=4, FAULT=5. Codes 6 and 7 are unreachable and recover to IDLE.
- All outputs are registered and are a function of the registered state:
  - IDLE: counter_run=0, enable_outputs=00.
  - ARMED: counter_run=1, enable_outputs=00.
  - BOOTSTRAP: counter_run=1, enable_outputs=output_mask & 2'b10.
  - RUN and STOPPING: counter_run=1, enable_outputs=output_mask. The mask is sampled every cycle, so a mask change appears 1 cycle later.
  - FAULT: counter_run=0, enable_outputs=00, fault_latched=1.
- Transition priority, highest first: reset, fault, stop, others.
- fault=1 in any state other than FAULT -> FAULT.
- FAULT -> IDLE when fault_clear=1 and fault=0 in the same cycle. fault_clear while fault=1 is ignored.
- IDLE:
  - start=1 and stop=0 -> ARMED.
  - start and stop together -> stay IDLE.
- ARMED:
  - stop -> IDLE.
  - period_start with bootstrap_cycles=0 -> RUN.
  - period_start with bootstrap_cycles!=0 -> BOOTSTRAP, loading boot_cnt=bootstrap_cycles.
- BOOTSTRAP:
  - boot_cnt decrements by 1 each cycle while nonzero and saturates at 0.
  - stop -> IDLE.
  - period_start with boot_cnt==0 -> RUN. period_start with boot_cnt!=0 is ignored, so RUN always begins on a period boundary.
- RUN: stop -> STOPPING. start is ignored.
- STOPPING: period_start -> IDLE. start and stop are ignored. Fault still preempts.
- bootstrap_cycles is sampled only on entry to BOOTSTRAP. Changes mid-bootstrap have no effect.

## Timing
- Reset values: state=0, counter_run=0, enable_outputs=00, fault_latched=0, boot_cnt=0.
- Latency from an input sampled in cycle t to the state/output change is exactly 1 cycle (visible in t+1).
- Fault shutdown latency is 1 cycle: enable_outputs=00 and counter_run=0 from t+1.
- Bootstrap duration:
  - Entered at cycle p+1.
  - boot_cnt reaches 0 at p+1+N.
  - RUN begins the cycle after the first period_start at or after p+1+N.
- Stop from RUN:
  - Outputs stay at output_mask through the cycle carrying the next period_start (cycle q).
  - IDLE, with counter_run=0 and enable_outputs=00, from q+1.
- Reset mid-operation returns to the reset values on the next edge regardless of fault.

## Test plan
1. Normal start:
   - Stimulus: reset, output_mask=11, bootstrap_cycles=10, period_start every 100 cycles, start at t=5.
   - Required: ARMED at t=6 with counter_run=1; at the first period_start, BOOTSTRAP with enable=10 for one full period; RUN with enable=11 after the next period_start.
2. Zero bootstrap:
   - Stimulus: bootstrap_cycles=0, start.
   - Required: ARMED -> RUN directly on the first period_start; enable=00 -> 11 with no intermediate 10.
3. Aligned stop:
   - Stimulus: in RUN, stop asserted 30 cycles before period_start.
   - Required: STOPPING with enable=11 held; IDLE with enable=00 and counter_run=0 exactly 1 cycle after period_start.
4. Fault during RUN:
   - Stimulus: fault=1 for 1 cycle, then fault_clear while fault=1, then fault_clear after fault=0.
   - Required: FAULT with outputs 00 and counter_run=0 next cycle; the first clear is ignored; the second clear gives IDLE; start then re-arms normally.
5. Simultaneous events:
   - start+stop in IDLE -> stays IDLE.
   - fault+stop in RUN -> FAULT.
   - stop in BOOTSTRAP -> IDLE next cycle with enable=00.
6. Reset mid-BOOTSTRAP with fault=1:
   - Required: all outputs at reset values on the next edge.
   - After release with fault still 1, FAULT is entered the following cycle.
